// File: rtl/timer_bcd.sv
// timer_bcd: BCD countdown timer with keypad entry, run/pause control and door interlock.
// Three-state FSM (IDLE, RUN, PAUSED) with one prioritised event acting per cycle.
module timer_bcd (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1hz,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    input  logic       door_closed,
    output logic [3:0] mins,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       magnetron_on,
    output logic       done
);
    typedef enum logic [1:0] {IDLE, RUN, PAUSED} state_t;
    state_t     state_q, state_d;
    logic [3:0] mins_q, mins_d, tens_q, tens_d, ones_q, ones_d;
    logic       done_q, done_d, mag_q;
    logic       nonzero, last_sec;
    assign nonzero  = |{mins_q, tens_q, ones_q};
    assign last_sec = mins_q == 4'd0 && tens_q == 4'd0 && ones_q == 4'd1;
    always_comb begin
        state_d = state_q;
        mins_d  = mins_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        done_d  = 1'b0;
        if (clear) begin
            state_d = IDLE;
            mins_d  = 4'd0;
            tens_d  = 4'd0;
            ones_d  = 4'd0;
        end else if (state_q == RUN && !door_closed) begin
            state_d = PAUSED;
        end else if (stop) begin
            state_d = state_q == RUN ? PAUSED : IDLE;
            mins_d  = state_q == RUN ? mins_q : 4'd0;
            tens_d  = state_q == RUN ? tens_q : 4'd0;
            ones_d  = state_q == RUN ? ones_q : 4'd0;
        end else if (start && state_q != RUN && door_closed && nonzero) begin
            state_d = RUN;
        end else if (tick_1hz && state_q == RUN) begin
            // Borrow chain; unnormalised tens (6-9) simply count down as seconds.
            ones_d = ones_q != 4'd0 ? ones_q - 4'd1 : 4'd9;
            tens_d = ones_q != 4'd0 ? tens_q : (tens_q != 4'd0 ? tens_q - 4'd1 : 4'd5);
            mins_d = (ones_q == 4'd0 && tens_q == 4'd0) ? mins_q - 4'd1 : mins_q;
            state_d = last_sec ? IDLE : RUN;
            done_d  = last_sec;
        end else if (key_valid && state_q == IDLE && key_code <= 4'd9) begin
            mins_d = tens_q;
            tens_d = ones_q;
            ones_d = key_code;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mins_q  <= 4'd0;
            tens_q  <= 4'd0;
            ones_q  <= 4'd0;
            done_q  <= 1'b0;
            mag_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mins_q  <= mins_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
            done_q  <= done_d;
            mag_q   <= state_d == RUN;
        end
    end
    assign mins         = mins_q;
    assign sec_tens     = tens_q;
    assign sec_ones     = ones_q;
    assign magnetron_on = mag_q;
    assign done         = done_q;
endmodule

// File: tb/tb_timer_bcd.sv
// tb_timer_bcd: directed and randomized checks of timer_bcd against a minutes/seconds reference model.
module tb_timer_bcd;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick_1hz = 1'b0, key_valid = 1'b0, start = 1'b0, stop = 1'b0, clear = 1'b0;
    logic       door_closed = 1'b1;
    logic [3:0] key_code = 4'd0;
    logic [3:0] mins, sec_tens, sec_ones;
    logic       magnetron_on, done;
    int         passed = 0, total = 0;
    int         m_min = 0, m_sec = 0, m_mode = 0, m_done = 0;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2;
    timer_bcd dut (
        .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz), .key_valid(key_valid), .key_code(key_code),
        .start(start), .stop(stop), .clear(clear), .door_closed(door_closed),
        .mins(mins), .sec_tens(sec_tens), .sec_ones(sec_ones),
        .magnetron_on(magnetron_on), .done(done)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input int obs, input int exp);
        total++;
        if (obs == exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask
    // Reference: whole minutes plus a 0-99 seconds field; digits derived arithmetically.
    task automatic model(input bit rn, clr, dc, stp, sta, tk, kv, input int kc);
        m_done = 0;
        if (!rn || clr) begin
            m_min = 0; m_sec = 0; m_mode = M_IDLE;
        end else if (m_mode == M_RUN && !dc) begin
            m_mode = M_PAUSED;
        end else if (stp) begin
            if (m_mode == M_RUN) m_mode = M_PAUSED;
            else begin m_min = 0; m_sec = 0; m_mode = M_IDLE; end
        end else if (sta && m_mode != M_RUN && dc && (m_min + m_sec) != 0) begin
            m_mode = M_RUN;
        end else if (tk && m_mode == M_RUN) begin
            if (m_sec > 0) m_sec--;
            else begin m_min--; m_sec = 59; end
            if (m_min == 0 && m_sec == 0) begin m_mode = M_IDLE; m_done = 1; end
        end else if (kv && m_mode == M_IDLE && kc <= 9) begin
            m_min = m_sec / 10;
            m_sec = (m_sec % 10) * 10 + kc;
        end
    endtask
    task automatic step(input bit rn, clr, dc, stp, sta, tk, kv, input int kc);
        rst_n = rn; clear = clr; door_closed = dc; stop = stp; start = sta;
        tick_1hz = tk; key_valid = kv; key_code = kc[3:0];
        @(posedge clk);
        model(rn, clr, dc, stp, sta, tk, kv, kc);
        #1;
        check("mins", mins, m_min);
        check("sec_tens", sec_tens, m_sec / 10);
        check("sec_ones", sec_ones, m_sec % 10);
        check("magnetron_on", magnetron_on, m_mode == M_RUN);
        check("done", done, m_done);
    endtask
    task automatic idle(); step(1, 0, 1, 0, 0, 0, 0, 0); endtask
    task automatic key(input int k); step(1, 0, 1, 0, 0, 0, 1, k); endtask
    task automatic go(); step(1, 0, 1, 0, 1, 0, 0, 0); endtask
    task automatic tick(input bit dc); step(1, 0, dc, 0, 0, 1, 0, 0); endtask
    task automatic clr(); step(1, 1, 1, 0, 0, 0, 0, 0); endtask
    function automatic int disp();
        return {mins, sec_tens, sec_ones};
    endfunction
    initial begin
        step(0, 0, 1, 0, 0, 0, 0, 0);
        check("rst_disp", disp(), 'h000);
        check("rst_mag", magnetron_on, 0);
        key(1); key(3); key(0);
        check("key_130", disp(), 'h130);
        key(7);
        check("key_307", disp(), 'h307);
        key(12);
        check("key_12_ignored", disp(), 'h307);
        clr(); key(1); key(0); key(0); go();
        check("run_mag", magnetron_on, 1);
        tick(1);
        check("borrow_059", disp(), 'h059);
        clr(); key(1); key(0); go(); tick(1);
        check("borrow_009", disp(), 'h009);
        clr(); key(1); go(); tick(1);
        check("done_disp", disp(), 'h000);
        check("done_pulse", done, 1);
        check("done_mag", magnetron_on, 0);
        tick(1);
        check("done_one_cycle", done, 0);
        clr(); key(4); key(5); go(); tick(0);
        check("door_pause", disp(), 'h045);
        check("door_mag", magnetron_on, 0);
        tick(0); tick(1);
        check("paused_ticks", disp(), 'h045);
        go();
        check("resume_mag", magnetron_on, 1);
        tick(1);
        check("resume_tick", disp(), 'h044);
        clr(); go();
        check("zero_start", magnetron_on, 0);
        key(3); key(0); step(1, 0, 0, 0, 1, 0, 0, 0);
        check("door_open_start", magnetron_on, 0);
        clr(); key(2); key(0); go(); step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 1, 1, 0, 0, 0, 0);
        check("stop_paused", disp(), 'h000);
        key(5);
        check("stop_to_idle", disp(), 'h005);
        clr(); key(2); key(0); key(0); go();
        step(1, 1, 1, 1, 0, 1, 0, 0);
        check("prio_disp", disp(), 'h000);
        check("prio_done", done, 0);
        check("prio_mag", magnetron_on, 0);
        key(1); key(1); key(5); go(); tick(1);
        step(0, 0, 1, 0, 0, 1, 0, 0);
        check("rst_run_disp", disp(), 'h000);
        check("rst_run_mag", magnetron_on, 0);
        idle();
        check("rst_no_done", done, 0);
        key(1); key(9); key(0); go();
        for (int i = 0; i < 91; i++) tick(1);
        check("unnorm_wrap", disp(), 'h059);
        for (int i = 0; i < 5000; i++)
            step($urandom_range(199) != 0, $urandom_range(59) == 0, $urandom_range(9) != 0,
                 $urandom_range(24) == 0, $urandom_range(7) == 0, $urandom_range(2) == 0,
                 $urandom_range(2) == 0, $urandom_range(15));
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/timer_bcd.md
TIMER_BCD -- requirements
Module: timer_bcd

Interface
REQ-001 Parameters: none; all widths fixed.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 tick_1hz  in  1  one-cycle enable pulse, once per second.
REQ-005 key_valid  in  1  one-cycle strobe; key_code is valid this cycle.
REQ-006 key_code  in  4  keypad digit, binary 0-9.
REQ-007 start  in  1  one-cycle pulse, start or resume.
REQ-008 stop  in  1  one-cycle pulse, pause or cancel.
REQ-009 clear  in  1  one-cycle pulse, abort and zero.
REQ-010 door_closed  in  1  level; 1 = door closed.
REQ-011 mins  out  4  BCD minutes digit, registered.
REQ-012 sec_tens  out  4  BCD tens-of-seconds digit, registered.
REQ-013 sec_ones  out  4  BCD units-of-seconds digit, registered.
REQ-014 magnetron_on  out  1  registered; 1 exactly while state = RUN.
REQ-015 done  out  1  registered one-cycle pulse when countdown reaches 0:00.

Function
REQ-016 The FSM shall have the states IDLE, RUN and PAUSED, and outputs shall change only on clock edges.
REQ-017 Each cycle's event priority shall be: clear, then door open (door_closed=0), then stop, then start, then tick_1hz, then key_valid; only the highest-priority applicable event shall act.
REQ-018 clear in any state shall set all digits to 0, the state to IDLE and magnetron_on to 0, with done=0.
REQ-019 In IDLE, key_valid with key_code <= 9 shall shift the digits left: mins<=sec_tens, sec_tens<=sec_ones, sec_ones<=key_code; the old mins digit is discarded.
REQ-020 key_code > 9, and key_valid in RUN or PAUSED, shall be ignored with no state change.
REQ-021 start in IDLE or PAUSED shall enter RUN next cycle only if door_closed=1 and the digits are not all zero; otherwise it shall be ignored.
REQ-022 In RUN, door_closed=0 shall move the FSM to PAUSED next cycle, with digits unchanged and any coincident tick ignored.
REQ-023 stop in RUN shall move to PAUSED; stop in PAUSED shall zero the digits and move to IDLE; stop in IDLE shall zero the digits.
REQ-024 In RUN, each tick_1hz shall decrement the time by one second, with BCD borrow:
  - sec_ones 1-9: sec_ones-1.
  - sec_ones 0, sec_tens>0: sec_ones=9, sec_tens-1.
  - both 0, mins>0: sec_ones=9, sec_tens=5, mins-1.
REQ-025 Entered sec_tens values 6-9 shall be accepted unnormalised and count down as seconds; for example, 1:90 counts 90 s and then wraps to 0:59.
REQ-026 A tick that changes the time from 0:01 to 0:00 shall, in the same edge, set state=IDLE and magnetron_on=0, and set done=1 for exactly one cycle.
REQ-027 tick_1hz in IDLE or PAUSED shall be ignored.
REQ-028 All outputs shall stay within 0-9 per digit at all times; no value outside BCD is ever driven.
REQ-029 magnetron_on shall equal 1 in the cycle after entry to RUN and shall drop in the cycle after leaving RUN.

Reset
REQ-030 While rst_n=0 at a clock edge, the block shall set: state=IDLE, mins=sec_tens=sec_ones=0, magnetron_on=0, done=0.
REQ-031 Reset shall override every other input, including mid-countdown; no done pulse shall be produced by reset.
REQ-032 The first non-reset edge shall process inputs normally.

Verification
REQ-033 Key entry: after reset, keys 1,3,0 -> 1:30. A further key 7 -> 3:07. Key 12 -> 3:07 unchanged.
REQ-034 Countdown borrow: load 1:00, door closed, start -> magnetron_on=1. One tick -> 0:59. From 0:10, one tick -> 0:09.
REQ-035 Completion: at 0:01 in RUN, one tick -> 0:00, done=1 for one cycle, magnetron_on=0, state IDLE. A further tick -> no change and done=0.
REQ-036 Door/pause: in RUN at 0:45, door_closed=0 together with a tick -> PAUSED at 0:45, magnetron_on=0. Ticks are ignored. Door closed plus start -> RUN resumes from 0:45.
REQ-037 Illegal or zero start: with 0:00, start -> stays IDLE. With door open at 0:30, start -> stays IDLE. stop in PAUSED at 0:20 -> 0:00, IDLE.
REQ-038 Priority/reset: in RUN at 2:00, assert clear+stop+tick together -> 0:00 IDLE, done=0. Reset mid-RUN at 1:15 -> 0:00, magnetron_on=0, no done pulse.
